// File: rtl/csa_pkg.sv
// Shared types and width helpers for the CSA accumulation path.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} csa_state_e;

    localparam int CSA_W = 24;

    function automatic int res_width(int w);
        return w + 2;
    endfunction

    function automatic int nchunks(int res_w, int chunk);
        return (res_w + chunk - 1) / chunk;
    endfunction

    // Result width reused by the CSA tree top: holds (2^W-1)+(2^(W+1)-1).
    localparam int CSA_RES_W = res_width(CSA_W);

endpackage

// File: rtl/csa_resolve_cpa_if.sv
// Operand/result handshake bundle between the last CSA stage and writeback.
interface csa_resolve_cpa_if
    import csa_pkg::*;
#(
    parameter int W = 24
);
    localparam int RES_W = res_width(W);

    logic             in_valid;
    logic             in_ready;
    logic [W:1]       in_sum;
    logic [W+1:1]     in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W:1]   out_result;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/csa_resolve_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module csa_resolve_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_cpa.sv
// Chunk-serial carry-propagate resolve of a carry-save pair into one binary result.
module csa_resolve_cpa
    import csa_pkg::*;
#(
    parameter int W     = 24,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    csa_resolve_cpa_if.slave   bus
);

    localparam int RES_W = res_width(W);
    localparam int NCH   = nchunks(RES_W, CHUNK);
    localparam int PAD_W = NCH * CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    csa_state_e         state_q, state_d;
    logic [PAD_W-1:0]   opa_q, opb_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [RES_W-1:0]   res_q, res_d;
    logic [CHUNK-1:0]   csum;
    logic               cout;
    logic               accept;
    logic               last;
    int                 base;

    assign last = (idx_q == IDX_W'(NCH - 1));

    always_comb base = int'(idx_q) * CHUNK;

    csa_resolve_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (opa_q[base +: CHUNK]),
        .b    (opb_q[base +: CHUNK]),
        .cin  (carry_q),
        .sum  (csum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bits of the top chunk that land above RES_W are dropped here.
    always_comb begin
        res_d = res_q;
        for (int i = 0; i < CHUNK; i++) begin
            if (base + i < RES_W) res_d[base + i] = csum[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            opa_q   <= PAD_W'(bus.in_sum);
            opb_q   <= PAD_W'(bus.in_carry);
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == RUN) begin
            res_q   <= res_d;
            carry_q <= cout;
            idx_q   <= idx_q + IDX_W'(1);
        end
    end

    assign bus.out_result = res_q;

    // RES_W is wide enough that the top chunk never carries out.
    a_final_carry_zero : assert property (
        @(posedge clk) disable iff (rst) (state_q == RUN && last) |-> !cout
    );

endmodule
